load_store_unit: RTL

- Initiator side of the core's data-memory interface; sits between execute stage and data memory.
- Accepts one load/store per handshake and drives word-aligned memory requests with byte enables.
- Aligns store data into byte lanes; extracts and sign/zero-extends load data.
- Flags misaligned/illegal accesses and memory timeouts; stalls the pipeline via req_ready.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width encodings, FSM states, lane masks.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } lsu_state_e;

   // Misaligned address or an encoding that has no meaning for this op.
   function automatic logic access_err(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
      logic err;
      err = 1'b0;
      case (funct3)
         F3_B, F3_BU: err = 1'b0;
         F3_H, F3_HU: err = addr_lo[0];
         F3_W:        err = (addr_lo != 2'b00);
         default:     err = 1'b1;
      endcase
      if (is_store && funct3[2]) err = 1'b1;
      return err;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication, byte enables, load extraction and extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        sign;

   always_comb begin
      lane_b = rdata_i[7:0];
      case (addr_lo_i)
         2'd1:    lane_b = rdata_i[15:8];
         2'd2:    lane_b = rdata_i[23:16];
         2'd3:    lane_b = rdata_i[31:24];
         default: lane_b = rdata_i[7:0];
      endcase
      lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      sign      = 1'b0;
      byte_en_o = BE_W;
      wdata_o   = wdata_i;
      rdata_o   = rdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            byte_en_o = BE_B << addr_lo_i;
            wdata_o   = {4{wdata_i[7:0]}};
            sign      = lane_b[7] & ~funct3_i[2];
            rdata_o   = {{24{sign}}, lane_b};
         end
         2'b01: begin
            byte_en_o = BE_H << addr_lo_i;
            wdata_o   = {2{wdata_i[15:0]}};
            sign      = lane_h[15] & ~funct3_i[2];
            rdata_o   = {{16{sign}}, lane_h};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, word-aligned requests, error and timeout flags.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_is_store_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_misaligned_o,
   output logic              resp_timeout_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wr_en_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_byte_en_o,
   input  logic              mem_ready_i,
   input  logic [31:0]       mem_rdata_i
);

   localparam int unsigned   CntW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   lsu_state_e        state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              mis_q, mis_d;
   logic              to_q, to_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic [3:0]  byte_en;
   logic [31:0] wdata_rep;
   logic [31:0] load_ext;

   lsu_align u_align (
      .funct3_i  (funct3_q),
      .addr_lo_i (addr_q[1:0]),
      .wdata_i   (wdata_q),
      .rdata_i   (mem_rdata_i),
      .byte_en_o (byte_en),
      .wdata_o   (wdata_rep),
      .rdata_o   (load_ext)
   );

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      mis_d      = mis_q;
      to_d       = to_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               is_store_d = req_is_store_i;
               funct3_d   = req_funct3_i;
               addr_d     = req_addr_i;
               wdata_d    = req_wdata_i;
               rdata_d    = '0;
               to_d       = 1'b0;
               cnt_d      = '0;
               mis_d      = access_err(req_is_store_i, req_funct3_i, req_addr_i[1:0]);
               state_d    = mis_d ? StResp : StAccess;
            end
         end
         StAccess: begin
            if (mem_ready_i) begin
               if (!is_store_q) rdata_d = load_ext;
               state_d = StResp;
            end else if (cnt_q == CntLast) begin
               to_d    = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         is_store_q <= 1'b0;
         funct3_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         mis_q      <= 1'b0;
         to_q       <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         funct3_q   <= funct3_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         mis_q      <= mis_d;
         to_q       <= to_d;
         cnt_q      <= cnt_d;
      end
   end

   assign req_ready_o       = (state_q == StIdle) && !reset_i;
   assign mem_req_o         = (state_q == StAccess);
   assign mem_addr_o        = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wr_en_o       = mem_req_o && is_store_q;
   assign mem_wdata_o       = wdata_rep;
   assign mem_byte_en_o     = mem_req_o ? byte_en : 4'b0000;
   assign resp_valid_o      = (state_q == StResp);
   assign resp_rdata_o      = resp_valid_o ? rdata_q : 32'h0;
   assign resp_misaligned_o = resp_valid_o && mis_q;
   assign resp_timeout_o    = resp_valid_o && to_q;

endmodule
